// File: rtl/decimal_to_dcb_encoder_pkg.sv
// ============================================================================
//  Module   : decimal_to_dcb_encoder_pkg
//  Purpose  : Shared digit-width constants for the decimal/octal encoder slice.
//  Contents : DEC_W  - width of the one-hot decimal digit code (10)
//             DCB_W  - width of the binary-coded decimal digit   (4)
//             OCT_W  - width of the one-hot octal code           (8)
//             BIN_W  - width of the 3-bit binary index           (3)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decimal_to_dcb_encoder_pkg;

    localparam int DEC_W = 10;
    localparam int DCB_W = 4;
    localparam int OCT_W = 8;
    localparam int BIN_W = 3;

endpackage : decimal_to_dcb_encoder_pkg

`default_nettype wire

// File: rtl/decimal_to_dcb_encoder_onehot_prio_enc.sv
// ============================================================================
//  Module   : onehot_prio_enc
//  Purpose  : Generic combinational priority one-hot-to-index encoder.
//             The highest set bit wins, so a multi-hot input still yields a
//             well-defined index alongside an error flag.
//  Params   : IN_W   - number of one-hot input bits
//             IDX_W  - width of the index output
//  Ports    : i_onehot [IN_W-1:0]  one-hot (ideally) input code
//             o_idx    [IDX_W-1:0] index of the highest set bit, 0 if none
//             o_valid              at least one input bit set
//             o_err                more than one input bit set
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_prio_enc #(
    parameter int IN_W  = 8,
    parameter int IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1
) (
    input  logic [IN_W-1:0]  i_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid,
    output logic             o_err
);

    logic [IDX_W-1:0] w_idx;
    logic [IN_W-1:0]  w_low_cleared;

    // Ascending scan: a later (higher) set bit overwrites an earlier one,
    // which gives highest-bit priority without a separate priority chain.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (i_onehot[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit; anything left means multi-hot.
    assign w_low_cleared = i_onehot & (i_onehot - IN_W'(1));

    assign o_idx   = w_idx;
    assign o_valid = |i_onehot;
    assign o_err   = |w_low_cleared;

endmodule : onehot_prio_enc

`default_nettype wire

// File: rtl/decimal_to_dcb_encoder.sv
// ============================================================================
//  Module   : decimal_to_dcb_encoder
//  Purpose  : Three independent registered code-conversion paths:
//               decimal (one-hot 10) -> dcb (4-bit digit) + valid/err
//               octal   (one-hot 8)  -> binary (3-bit)    + valid/err
//               binary1 (3-bit)      -> octal1 (one-hot 8)
//             Every output is registered with exactly one cycle of latency.
//  Ports    : clk          clock, rising-edge
//             rst          synchronous active-high reset (clears all outputs)
//             decimal[9:0] one-hot decimal digit code
//             dcb[3:0]     binary-coded digit of decimal (highest bit wins)
//             dcb_valid    decimal had at least one bit set
//             dcb_err      decimal had more than one bit set
//             octal[7:0]   one-hot octal code
//             binary[2:0]  index of octal (highest bit wins)
//             binary_valid octal had at least one bit set
//             binary_err   octal had more than one bit set
//             binary1[2:0] binary value to decode
//             octal1[7:0]  one-hot decode of binary1
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decimal_to_dcb_encoder
    import decimal_to_dcb_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DEC_W-1:0] decimal,
    output logic [DCB_W-1:0] dcb,
    output logic             dcb_valid,
    output logic             dcb_err,
    input  logic [OCT_W-1:0] octal,
    output logic [BIN_W-1:0] binary,
    output logic             binary_valid,
    output logic             binary_err,
    input  logic [BIN_W-1:0] binary1,
    output logic [OCT_W-1:0] octal1
);

    logic [DCB_W-1:0] w_dec_idx;
    logic             w_dec_valid;
    logic             w_dec_err;
    logic [BIN_W-1:0] w_oct_idx;
    logic             w_oct_valid;
    logic             w_oct_err;
    logic [OCT_W-1:0] w_oct1_dec;

    logic [DCB_W-1:0] r_dcb;
    logic             r_dcb_valid;
    logic             r_dcb_err;
    logic [BIN_W-1:0] r_binary;
    logic             r_binary_valid;
    logic             r_binary_err;
    logic [OCT_W-1:0] r_octal1;

    onehot_prio_enc #(
        .IN_W  (DEC_W),
        .IDX_W (DCB_W)
    ) u_dec_enc (
        .i_onehot (decimal),
        .o_idx    (w_dec_idx),
        .o_valid  (w_dec_valid),
        .o_err    (w_dec_err)
    );

    onehot_prio_enc #(
        .IN_W  (OCT_W),
        .IDX_W (BIN_W)
    ) u_oct_enc (
        .i_onehot (octal),
        .o_idx    (w_oct_idx),
        .o_valid  (w_oct_valid),
        .o_err    (w_oct_err)
    );

    // 3->8 decode: always exactly one bit set, including binary1 == 0.
    assign w_oct1_dec = OCT_W'(1) << binary1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dcb          <= '0;
            r_dcb_valid    <= 1'b0;
            r_dcb_err      <= 1'b0;
            r_binary       <= '0;
            r_binary_valid <= 1'b0;
            r_binary_err   <= 1'b0;
            r_octal1       <= '0;
        end else begin
            r_dcb          <= w_dec_idx;
            r_dcb_valid    <= w_dec_valid;
            r_dcb_err      <= w_dec_err;
            r_binary       <= w_oct_idx;
            r_binary_valid <= w_oct_valid;
            r_binary_err   <= w_oct_err;
            r_octal1       <= w_oct1_dec;
        end
    end

    assign dcb          = r_dcb;
    assign dcb_valid    = r_dcb_valid;
    assign dcb_err      = r_dcb_err;
    assign binary       = r_binary;
    assign binary_valid = r_binary_valid;
    assign binary_err   = r_binary_err;
    assign octal1       = r_octal1;

endmodule : decimal_to_dcb_encoder

`default_nettype wire

// File: tb/tb_decimal_to_dcb_encoder.sv
// ============================================================================
//  Module   : tb_decimal_to_dcb_encoder
//  Purpose  : Directed self-checking bench for decimal_to_dcb_encoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decimal_to_dcb_encoder;

    logic       clk;
    logic       rst;
    logic [9:0] decimal;
    logic [3:0] dcb;
    logic       dcb_valid;
    logic       dcb_err;
    logic [7:0] octal;
    logic [2:0] binary;
    logic       binary_valid;
    logic       binary_err;
    logic [2:0] binary1;
    logic [7:0] octal1;

    int n_checks;
    int n_errors;

    // Hand-written expected one-hot patterns for binary1 = 0..7.
    logic [7:0] c_oct1_tab [8];

    decimal_to_dcb_encoder u_dut (
        .clk          (clk),
        .rst          (rst),
        .decimal      (decimal),
        .dcb          (dcb),
        .dcb_valid    (dcb_valid),
        .dcb_err      (dcb_err),
        .octal        (octal),
        .binary       (binary),
        .binary_valid (binary_valid),
        .binary_err   (binary_err),
        .binary1      (binary1),
        .octal1       (octal1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s : got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Drive inputs away from the edge, then sample just after the next edge.
    task automatic apply(input logic [9:0] dec, input logic [7:0] oct, input logic [2:0] b1);
        @(negedge clk);
        decimal = dec;
        octal   = oct;
        binary1 = b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        c_oct1_tab[0] = 8'b00000001;
        c_oct1_tab[1] = 8'b00000010;
        c_oct1_tab[2] = 8'b00000100;
        c_oct1_tab[3] = 8'b00001000;
        c_oct1_tab[4] = 8'b00010000;
        c_oct1_tab[5] = 8'b00100000;
        c_oct1_tab[6] = 8'b01000000;
        c_oct1_tab[7] = 8'b10000000;

        rst     = 1'b1;
        decimal = 10'h3FF;
        octal   = 8'hFF;
        binary1 = 3'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dcb",          32'(dcb),          32'd0);
        chk("rst_dcb_valid",    32'(dcb_valid),    32'd0);
        chk("rst_dcb_err",      32'(dcb_err),      32'd0);
        chk("rst_binary",       32'(binary),       32'd0);
        chk("rst_binary_valid", 32'(binary_valid), 32'd0);
        chk("rst_binary_err",   32'(binary_err),   32'd0);
        chk("rst_octal1",       32'(octal1),       32'd0);

        @(negedge clk);
        rst = 1'b0;

        // Single-hot decimal endpoints.
        apply(10'b0000000001, 8'b00000001, 3'd0);
        chk("dec0_dcb",   32'(dcb),       32'd0);
        chk("dec0_valid", 32'(dcb_valid), 32'd1);
        chk("dec0_err",   32'(dcb_err),   32'd0);

        // Latency: just after changing the input, output still holds old value.
        @(negedge clk);
        decimal = 10'b1000000000;
        #1;
        chk("lat_hold_dcb", 32'(dcb), 32'd0);
        @(posedge clk);
        #1;
        chk("dec9_dcb",   32'(dcb),       32'd9);
        chk("dec9_valid", 32'(dcb_valid), 32'd1);
        chk("dec9_err",   32'(dcb_err),   32'd0);

        // Octal walk and binary1 sweep, run together; decimal held at digit 3
        // to show the other paths leave it alone.
        for (int i = 0; i < 8; i++) begin
            apply(10'b0000001000, 8'(1 << i), 3'(i));
            chk("oct_walk_bin",   32'(binary),       32'(i));
            chk("oct_walk_valid", 32'(binary_valid), 32'd1);
            chk("oct_walk_err",   32'(binary_err),   32'd0);
            chk("b1_sweep_oct1",  32'(octal1),       32'(c_oct1_tab[i]));
            chk("indep_dcb",      32'(dcb),          32'd3);
        end

        // Multi-hot: highest bit wins, error flagged.
        apply(10'b0000100100, 8'b00010010, 3'd2);
        chk("multi_dcb",       32'(dcb),          32'd5);
        chk("multi_dcb_valid", 32'(dcb_valid),    32'd1);
        chk("multi_dcb_err",   32'(dcb_err),      32'd1);
        chk("multi_bin",       32'(binary),       32'd4);
        chk("multi_bin_valid", 32'(binary_valid), 32'd1);
        chk("multi_bin_err",   32'(binary_err),   32'd1);

        // All bits set: decimal clamps to 9, octal to 7.
        apply(10'h3FF, 8'hFF, 3'd6);
        chk("all_dcb",     32'(dcb),     32'd9);
        chk("all_dcb_err", 32'(dcb_err), 32'd1);
        chk("all_bin",     32'(binary),  32'd7);
        chk("all_oct1",    32'(octal1),  32'h40);

        // Zero inputs.
        apply(10'd0, 8'd0, 3'd1);
        chk("zero_dcb",       32'(dcb),          32'd0);
        chk("zero_dcb_valid", 32'(dcb_valid),    32'd0);
        chk("zero_dcb_err",   32'(dcb_err),      32'd0);
        chk("zero_bin",       32'(binary),       32'd0);
        chk("zero_bin_valid", 32'(binary_valid), 32'd0);
        chk("zero_bin_err",   32'(binary_err),   32'd0);
        chk("zero_oct1",      32'(octal1),       32'h02);

        // Mid-operation reset with live inputs.
        @(negedge clk);
        decimal = 10'b0100000000;
        octal   = 8'b00100000;
        binary1 = 3'd7;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_dcb",       32'(dcb),          32'd0);
        chk("mrst_dcb_valid", 32'(dcb_valid),    32'd0);
        chk("mrst_bin",       32'(binary),       32'd0);
        chk("mrst_bin_valid", 32'(binary_valid), 32'd0);
        chk("mrst_oct1",      32'(octal1),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_dcb",   32'(dcb),       32'd8);
        chk("post_rst_valid", 32'(dcb_valid), 32'd1);
        chk("post_rst_bin",   32'(binary),    32'd5);
        chk("post_rst_oct1",  32'(octal1),    32'h80);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_decimal_to_dcb_encoder

`default_nettype wire

// File: doc/decimal_to_dcb_encoder.md
DECIMAL_TO_DCB_ENCODER -- requirements
Module: decimal_to_dcb_encoder

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 decimal  input  10  one-hot decimal digit code; bit i set means digit i (0..9).
REQ-005 dcb  output  4  registered binary-coded digit of decimal.
REQ-006 dcb_valid  output  1  registered; 1 when decimal had at least one bit set.
REQ-007 dcb_err  output  1  registered; 1 when decimal had more than one bit set.
REQ-008 octal  input  8  one-hot octal code; bit i set means value i (0..7).
REQ-009 binary  output  3  registered 3-bit binary index of octal.
REQ-010 binary_valid  output  1  registered; 1 when octal had at least one bit set.
REQ-011 binary_err  output  1  registered; 1 when octal had more than one bit set.
REQ-012 binary1  input  3  binary value 0..7 to decode.
REQ-013 octal1  output  8  registered one-hot decode of binary1.

Function
REQ-014 The three paths (decimal->dcb, octal->binary, binary1->octal1) SHALL be independent; no path affects another.
REQ-015 Each output SHALL be registered, updating on the rising clk edge following an input change (latency exactly 1 cycle), with no handshake; every cycle samples inputs.
REQ-016 For decimal with exactly one bit i set, dcb SHALL be i (4'b0000..4'b1001), dcb_valid=1, dcb_err=0.
REQ-017 For decimal with multiple bits set, dcb SHALL be the index of the highest set bit, dcb_valid=1, dcb_err=1.
REQ-018 For decimal == 0, dcb SHALL be 4'b0000, dcb_valid=0, dcb_err=0.
REQ-019 dcb SHALL never take values 10..15.
REQ-020 For octal with exactly one bit i set, binary SHALL be i, binary_valid=1, binary_err=0.
REQ-021 For octal with multiple bits set, binary SHALL be the index of the highest set bit, binary_valid=1, binary_err=1.
REQ-022 For octal == 0, binary SHALL be 3'b000, binary_valid=0, binary_err=0.
REQ-023 octal1 SHALL equal 8'b1 shifted left by binary1 (exactly one bit set for every binary1 value, including 0 -> 8'b00000001).
REQ-024 Inputs containing X/Z are outside scope; no defined output is required for them.

Reset
REQ-025 When rst is high at a rising clk edge, dcb, binary SHALL become 0, all valid/err flags 0, and octal1 SHALL become 8'b00000000.
REQ-026 Reset SHALL take priority over input sampling; the first post-reset edge with rst low SHALL register the then-current inputs.
REQ-027 Reset asserted mid-operation SHALL clear outputs at that edge regardless of inputs.

Structure
REQ-028 Digit-width constants (DEC_W=10, DCB_W=4, OCT_W=8, BIN_W=3) SHALL reside in a shared package.
REQ-029 A generic priority one-hot-to-index sub-module onehot_prio_enc (parameterised input width, outputs index, valid, multi-hot error) SHALL be instantiated twice (10->4, 8->3); the 3->8 decode SHALL be inline logic.

Verification
REQ-030 decimal=10'b0000000001 then 10'b1000000000 -> one cycle later dcb=0 then dcb=9 (4'b1001), dcb_valid=1, dcb_err=0.
REQ-031 octal walked 8'b00000001..8'b10000000 -> binary 3'b000..3'b111 each one cycle later, binary_valid=1, binary_err=0.
REQ-032 binary1 swept 0..7 -> octal1 8'b00000001..8'b10000000 one cycle later.
REQ-033 decimal=10'b0000100100, octal=8'b00010010 -> dcb=5, dcb_err=1; binary=4, binary_err=1.
REQ-034 decimal=0, octal=0 -> dcb=0, dcb_valid=0; binary=0, binary_valid=0.
REQ-035 rst=1 for one edge while decimal=10'b0100000000, binary1=3'b111 -> all outputs 0 that edge; after rst drops, next edge dcb=8, octal1=8'b10000000.
